// File: rtl/riscv_pkg.sv
// Shared core types and default widths for the memory arbiter.
package riscv_pkg;

  localparam int unsigned ARB_AW         = 32;
  localparam int unsigned ARB_DW         = 32;
  localparam int unsigned ARB_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DACC   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the fetch port and the data port.
// Data wins by default; a starvation counter lets fetch win after
// FETCH_STARVE_MAX consecutive data grants. One access in flight at most.
// FETCH_STARVE_MAX must be at least 1.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned AW               = ARB_AW,
  parameter int unsigned DW               = ARB_DW,
  parameter int unsigned FETCH_STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = $clog2(FETCH_STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(FETCH_STARVE_MAX);

  arb_state_t    state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          abandon_q, abandon_d;

  logic in_flight;
  logic done;
  logic grant_ok;
  logic fetch_starved;
  logic if_hit;
  logic dm_hit;
  logic owner_lost;

  // Request/response matching against the access currently on the memory bus
  always_comb begin
    in_flight     = (state_q != IDLE);
    done          = in_flight && mem_ready;
    grant_ok      = (state_q == IDLE) || done;
    fetch_starved = if_req && (starve_cnt_q == STARVE_MAX);
    if_hit        = if_req && (if_addr == mem_addr_q);
    dm_hit        = dm_req && (dm_addr == mem_addr_q) && (dm_we == mem_we_q);
    owner_lost    = ((state_q == IFETCH) && !if_hit) ||
                    ((state_q == DACC)   && !dm_hit);
  end

  // Stalls release only on a non-abandoned completion for the same request
  assign if_stall = if_req && !((state_q == IFETCH) && mem_ready && !abandon_q && if_hit);
  assign dm_stall = dm_req && !((state_q == DACC)   && mem_ready && !abandon_q && dm_hit);

  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Next-state, grant, abandon tracking and starvation counter
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    starve_cnt_d = starve_cnt_q;
    abandon_d    = abandon_q;

    // Owner flushed or redirected while the access is still in flight
    if (in_flight && !done && owner_lost) begin
      abandon_d = 1'b1;
    end

    if (grant_ok) begin
      abandon_d = 1'b0;
      if (dm_req && !fetch_starved) begin
        state_d     = DACC;
        mem_req_d   = 1'b1;
        mem_we_d    = dm_we;
        mem_addr_d  = dm_addr;
        mem_wdata_d = dm_wdata;
      end else if (if_req) begin
        state_d     = IFETCH;
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b0;
        mem_addr_d  = if_addr;
        mem_wdata_d = '0;
      end else begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    end

    if (!if_req) begin
      starve_cnt_d = '0;
    end else if (grant_ok && (state_d == DACC)) begin
      if (starve_cnt_q != STARVE_MAX) begin
        starve_cnt_d = starve_cnt_q + CW'(1);
      end
    end else if (grant_ok && (state_d == IFETCH)) begin
      starve_cnt_d = '0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory request hold registers, starvation counter and abandon flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      starve_cnt_q <= '0;
      abandon_q    <= 1'b0;
    end else begin
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      starve_cnt_q <= starve_cnt_d;
      abandon_q    <= abandon_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected grants
// and responses; a negedge monitor pops and compares as the DUT presents them.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  mem_arbiter #(
    .AW(32),
    .DW(32),
    .FETCH_STARVE_MAX(2)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_stall(if_stall),
    .dm_req(dm_req),
    .dm_we(dm_we),
    .dm_addr(dm_addr),
    .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata),
    .dm_stall(dm_stall),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  grant_t      exp_grant_q[$];
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_dm_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  int   mem_lat     = 1;
  logic manual_mode = 1'b0;
  logic manual_val  = 1'b0;
  logic [31:0] mem_model [logic [31:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] info);
    n_chk++;
    n_fail++;
    $display("FAIL %s: info 0x%08h at %0t", name, info, $time);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return 32'h0;
  endfunction

  task automatic push_grant(input logic we, input logic [31:0] a, input logic [31:0] wd);
    grant_t g;
    g.we = we;
    g.addr = a;
    g.wdata = wd;
    exp_grant_q.push_back(g);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: mem_ready on the mem_lat-th cycle of each request
  initial begin
    int  wait_cnt;
    logic busy;
    busy = 1'b0;
    wait_cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    mem_model[32'h10] = 32'h0050_0093;
    mem_model[32'h14] = 32'h00A0_0113;
    mem_model[32'h20] = 32'h1111_1111;
    mem_model[32'h30] = 32'h00C0_0193;
    mem_model[32'h40] = 32'h0000_0513;
    mem_model[32'h50] = 32'h0010_0073;
    mem_model[32'h60] = 32'h02A0_0293;
    mem_model[32'h200] = 32'h0BAD_F00D;
    forever begin
      @(posedge clk);
      #1;
      if (manual_mode) begin
        mem_ready = manual_val;
        mem_rdata = 32'hBAD0_BAD0;
        busy = 1'b0;
      end else begin
        mem_ready = 1'b0;
        if (mem_req && rst_n) begin
          if (!busy) begin
            busy = 1'b1;
            wait_cnt = mem_lat;
          end
          wait_cnt--;
          if (wait_cnt == 0) begin
            mem_ready = 1'b1;
            busy = 1'b0;
            if (mem_we) begin
              mem_model[mem_addr] = mem_wdata;
              mem_rdata = 32'h0;
            end else begin
              mem_rdata = mem_rd(mem_addr);
            end
          end
        end else begin
          busy = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expected grants and completions as the DUT presents them
  initial begin
    logic        prev_req;
    logic        prev_done;
    grant_t      g;
    logic [31:0] e;
    prev_req = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (mem_req && (!prev_req || prev_done)) begin
          if (exp_grant_q.size() == 0) begin
            fail_now("unexpected_grant", mem_addr);
          end else begin
            g = exp_grant_q.pop_front();
            chk("grant_we", 32'(mem_we), 32'(g.we));
            chk("grant_addr", mem_addr, g.addr);
            if (g.we) chk("grant_wdata", mem_wdata, g.wdata);
          end
        end
        if (if_req && !if_stall) begin
          if (exp_if_q.size() == 0) begin
            fail_now("unexpected_if_done", if_rdata);
          end else begin
            e = exp_if_q.pop_front();
            chk("if_rdata", if_rdata, e);
          end
        end
        if (dm_req && !dm_stall) begin
          if (exp_dm_q.size() == 0) begin
            fail_now("unexpected_dm_done", dm_rdata);
          end else begin
            e = exp_dm_q.pop_front();
            chk("dm_rdata", dm_rdata, e);
          end
        end
        prev_req = mem_req;
        prev_done = mem_req && mem_ready;
      end
    end
  end

  task automatic wait_if_done(input string name, output int stalls);
    logic seen;
    seen = 1'b0;
    stalls = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (!if_stall) seen = 1'b1;
      else stalls++;
    end
    if (!seen) fail_now(name, 32'(stalls));
  endtask

  task automatic wait_dm_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (!dm_stall) seen = 1'b1;
    end
    if (!seen) fail_now(name, 32'h0);
  endtask

  task automatic drain(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (!mem_req) seen = 1'b1;
    end
    if (!seen) fail_now(name, mem_addr);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    rst_n = 1'b1;
    if_req = 1'b0;
    if_addr = 32'h0;
    dm_req = 1'b0;
    dm_we = 1'b0;
    dm_addr = 32'h0;
    dm_wdata = 32'h0;
    manual_mode = 1'b1;
    manual_val = 1'b0;

    // 1: reset held while mem_ready toggles
    #3 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      manual_val = ~manual_val;
      @(negedge clk);
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_if_stall", 32'(if_stall), 32'h0);
      chk("rst_dm_stall", 32'(dm_stall), 32'h0);
    end
    rst_n = 1'b1;
    manual_val = 1'b0;
    manual_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_mem_req", 32'(mem_req), 32'h0);
    end
    step();

    // 2: single fetch, ready on the 2nd request cycle; completing fetch is re-granted
    mem_lat = 2;
    push_grant(1'b0, 32'h10, 32'h0);
    push_grant(1'b0, 32'h10, 32'h0);
    exp_if_q.push_back(32'h0050_0093);
    if_req = 1'b1;
    if_addr = 32'h10;
    wait_if_done("t2_if_timeout", st);
    chk("t2_stall_cycles", 32'(st), 32'd2);
    step();
    if_req = 1'b0;
    drain("t2_drain");

    // 3: simultaneous store and fetch -> data first, then fetch
    mem_lat = 1;
    push_grant(1'b1, 32'h100, 32'hDEAD_BEEF);
    push_grant(1'b1, 32'h100, 32'hDEAD_BEEF);
    push_grant(1'b0, 32'h14, 32'h0);
    push_grant(1'b0, 32'h14, 32'h0);
    exp_dm_q.push_back(32'h0);
    exp_if_q.push_back(32'h00A0_0113);
    if_req = 1'b1;
    if_addr = 32'h14;
    dm_req = 1'b1;
    dm_we = 1'b1;
    dm_addr = 32'h100;
    dm_wdata = 32'hDEAD_BEEF;
    wait_dm_done("t3_dm_timeout");
    step();
    dm_req = 1'b0;
    dm_we = 1'b0;
    wait_if_done("t3_if_timeout", st);
    step();
    if_req = 1'b0;
    drain("t3_drain");

    // 4: both held high with starve max 2 -> D,D,I,D,D,I
    mem_lat = 1;
    push_grant(1'b0, 32'h100, 32'h0);
    push_grant(1'b0, 32'h100, 32'h0);
    push_grant(1'b0, 32'h30, 32'h0);
    push_grant(1'b0, 32'h100, 32'h0);
    push_grant(1'b0, 32'h100, 32'h0);
    push_grant(1'b0, 32'h30, 32'h0);
    for (int i = 0; i < 4; i++) exp_dm_q.push_back(32'hDEAD_BEEF);
    exp_if_q.push_back(32'h00C0_0193);
    if_req = 1'b1;
    if_addr = 32'h30;
    dm_req = 1'b1;
    dm_we = 1'b0;
    dm_addr = 32'h100;
    dm_wdata = 32'h0;
    repeat (6) @(posedge clk);
    #1;
    if_req = 1'b0;
    dm_req = 1'b0;
    drain("t4_drain");

    // 5: redirect mid-fetch; stale completion must not release the stall
    mem_lat = 2;
    push_grant(1'b0, 32'h20, 32'h0);
    push_grant(1'b0, 32'h40, 32'h0);
    push_grant(1'b0, 32'h40, 32'h0);
    exp_if_q.push_back(32'h0000_0513);
    if_req = 1'b1;
    if_addr = 32'h20;
    step();
    if_addr = 32'h40;
    @(negedge clk);
    chk("t5_stall_inflight", 32'(if_stall), 32'h1);
    @(negedge clk);
    chk("t5_stall_stale_done", 32'(if_stall), 32'h1);
    wait_if_done("t5_if_timeout", st);
    step();
    if_req = 1'b0;
    drain("t5_drain");

    // 7: flush then re-request same address -> abandoned response discarded
    mem_lat = 3;
    push_grant(1'b0, 32'h60, 32'h0);
    push_grant(1'b0, 32'h60, 32'h0);
    push_grant(1'b0, 32'h60, 32'h0);
    exp_if_q.push_back(32'h02A0_0293);
    if_req = 1'b1;
    if_addr = 32'h60;
    step();
    if_req = 1'b0;
    step();
    if_req = 1'b1;
    @(negedge clk);
    chk("t7_stall_rereq", 32'(if_stall), 32'h1);
    @(negedge clk);
    chk("t7_stall_abandoned", 32'(if_stall), 32'h1);
    wait_if_done("t7_if_timeout", st);
    step();
    if_req = 1'b0;
    drain("t7_drain");

    // 6: reset mid data access, late mem_ready afterwards is ignored
    mem_lat = 4;
    push_grant(1'b0, 32'h200, 32'h0);
    dm_req = 1'b1;
    dm_we = 1'b0;
    dm_addr = 32'h200;
    step();
    step();
    rst_n = 1'b0;
    dm_req = 1'b0;
    dm_addr = 32'h0;
    @(negedge clk);
    chk("t6_rst_mem_req", 32'(mem_req), 32'h0);
    chk("t6_rst_mem_addr", mem_addr, 32'h0);
    chk("t6_rst_dm_stall", 32'(dm_stall), 32'h0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    manual_mode = 1'b1;
    manual_val = 1'b1;
    @(negedge clk);
    chk("t6_late_ready_req", 32'(mem_req), 32'h0);
    chk("t6_late_ready_if_stall", 32'(if_stall), 32'h0);
    manual_val = 1'b0;
    manual_mode = 1'b0;
    @(negedge clk);
    chk("t6_after_late_req", 32'(mem_req), 32'h0);
    chk("t6_after_late_we", 32'(mem_we), 32'h0);
    step();
    mem_lat = 1;
    push_grant(1'b0, 32'h50, 32'h0);
    push_grant(1'b0, 32'h50, 32'h0);
    exp_if_q.push_back(32'h0010_0073);
    if_req = 1'b1;
    if_addr = 32'h50;
    wait_if_done("t6_if_timeout", st);
    chk("t6_stall_cycles", 32'(st), 32'd1);
    step();
    if_req = 1'b0;
    drain("t6_drain");

    repeat (3) @(negedge clk);
    chk("left_grants", 32'(exp_grant_q.size()), 32'h0);
    chk("left_if_resp", 32'(exp_if_q.size()), 32'h0);
    chk("left_dm_resp", 32'(exp_dm_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
